// File: rtl/ahb_mux_nm1s.sv
// ----------------------------------------------------------------------------
// ahb_mux_nm1s -- N-master to 1-slave AHB-Lite interconnect multiplexer.
//
// Purpose
//   Shares one AHB-Lite slave port between NM masters. The address phase is
//   granted combinationally (zero wait states when uncontested). The master
//   that owns the data phase is tracked in a register. A master that
//   continues a burst with SEQ keeps the grant, so a burst is never split.
//
// Optional feature
//   AHB_MUX_RR_EN : when defined, arbitration is round-robin. The search
//                   starts at the master after the last one granted.
//                   When undefined, arbitration is fixed priority and the
//                   lowest index wins.
//
// Parameters
//   NM : number of masters (2..8)
//   DW : data width (32 or 64)
//
// Ports
//   HCLK, HRESET        clock; synchronous active-high reset
//   HADDR_M  [NM*32]    master addresses, master i at [i*32 +: 32]
//   HTRANS_M [NM*2]     master transfer types
//   HWRITE_M [NM]       master write controls
//   HSIZE_M  [NM*3]     master transfer sizes
//   HWDATA_M [NM*DW]    master write data
//   HREADY_M [NM]       per-master ready (low = stalled)
//   HRDATA_M [DW]       read data, broadcast to all masters
//   HRESP_M  [NM]       per-master error response
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA   slave-side request
//   HREADY/HRDATA/HRESP                slave-side response
// ----------------------------------------------------------------------------
module ahb_mux_nm1s #(
  parameter int NM = 3,
  parameter int DW = 64
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [NM*32-1:0] HADDR_M,
  input  logic [NM*2-1:0]  HTRANS_M,
  input  logic [NM-1:0]    HWRITE_M,
  input  logic [NM*3-1:0]  HSIZE_M,
  input  logic [NM*DW-1:0] HWDATA_M,
  output logic [NM-1:0]    HREADY_M,
  output logic [DW-1:0]    HRDATA_M,
  output logic [NM-1:0]    HRESP_M,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [DW-1:0]    HWDATA,
  input  logic             HREADY,
  input  logic [DW-1:0]    HRDATA,
  input  logic             HRESP
);

  localparam int IW = $clog2(NM);

  // Unpacked per-master views of the flattened buses.
  logic [31:0]   addr_m  [NM];
  logic [1:0]    trans_m [NM];
  logic [2:0]    size_m  [NM];
  logic [DW-1:0] wdata_m [NM];
  logic [NM-1:0] req;

  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_unpack
      assign addr_m[gi]  = HADDR_M[gi*32 +: 32];
      assign trans_m[gi] = HTRANS_M[gi*2 +: 2];
      assign size_m[gi]  = HSIZE_M[gi*3 +: 3];
      assign wdata_m[gi] = HWDATA_M[gi*DW +: DW];
      // NONSEQ and SEQ both have bit 1 set.
      assign req[gi]     = HTRANS_M[gi*2+1];
    end
  endgenerate

  logic          dval_reg;
  logic [IW-1:0] down_reg;
  logic [IW-1:0] last_reg;
  logic [IW-1:0] pick;
  logic [IW-1:0] gnt;
  logic          burst_lock;

  // The data-phase owner continuing its burst keeps the bus.
  assign burst_lock = dval_reg && (trans_m[down_reg] == 2'b11);

  // Arbitration. Candidates are visited from lowest to highest preference,
  // so the last match wins. With no requester, pick stays on last_reg.
  always_comb begin
    pick = last_reg;
`ifdef AHB_MUX_RR_EN
    for (int k = NM; k >= 1; k--) begin
      if (req[(int'(last_reg) + k) % NM]) begin
        pick = IW'((int'(last_reg) + k) % NM);
      end
    end
`else
    for (int k = NM - 1; k >= 0; k--) begin
      if (req[k]) begin
        pick = IW'(k);
      end
    end
`endif
  end

  assign gnt = burst_lock ? down_reg : pick;

  // Slave-side request.
  assign HADDR    = addr_m[gnt];
  assign HWRITE   = HWRITE_M[gnt];
  assign HSIZE    = size_m[gnt];
  assign HTRANS   = (!HRESET && req[gnt]) ? trans_m[gnt] : 2'b00;
  assign HWDATA   = dval_reg ? wdata_m[down_reg] : '0;
  assign HRDATA_M = HRDATA;

  // Per-master response. A master is released when it owns the data phase,
  // or when it has no data phase and either holds the grant or is not
  // asking for the bus. Only a losing requester is stalled.
  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_resp
      logic own_data;
      assign own_data     = dval_reg && (down_reg == IW'(gi));
      assign HREADY_M[gi] = (own_data || (gnt == IW'(gi)) || !req[gi]) ? HREADY : 1'b0;
      assign HRESP_M[gi]  = (!HRESET && own_data) ? HRESP : 1'b0;
    end
  endgenerate

  // Ownership advances only when the slave completes the current beat.
  // An error or wait cycle therefore leaves the owner unchanged.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dval_reg <= 1'b0;
      down_reg <= '0;
      last_reg <= IW'(NM - 1);
    end else if (HREADY) begin
      dval_reg <= req[gnt];
      down_reg <= gnt;
      if (req[gnt]) begin
        last_reg <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_ahb_mux_nm1s.sv
module tb_ahb_mux_nm1s;

  localparam int NM = 3;
  localparam int DW = 64;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic [NM*32-1:0] HADDR_M;
  logic [NM*2-1:0]  HTRANS_M;
  logic [NM-1:0]    HWRITE_M;
  logic [NM*3-1:0]  HSIZE_M;
  logic [NM*DW-1:0] HWDATA_M;
  logic [NM-1:0]    HREADY_M;
  logic [DW-1:0]    HRDATA_M;
  logic [NM-1:0]    HRESP_M;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [DW-1:0]    HWDATA;
  logic             HREADY;
  logic [DW-1:0]    HRDATA;
  logic             HRESP;

  always #5 HCLK = ~HCLK;

  ahb_mux_nm1s #(.NM(NM), .DW(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M),
    .HSIZE_M(HSIZE_M), .HWDATA_M(HWDATA_M),
    .HREADY_M(HREADY_M), .HRDATA_M(HRDATA_M), .HRESP_M(HRESP_M),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  // Per-master stimulus, packed onto the flat buses.
  logic [31:0]   m_addr  [NM];
  logic [1:0]    m_trans [NM];
  logic          m_write [NM];
  logic [2:0]    m_size  [NM];
  logic [DW-1:0] m_wdata [NM];

  always_comb begin
    HADDR_M  = '0;
    HTRANS_M = '0;
    HWRITE_M = '0;
    HSIZE_M  = '0;
    HWDATA_M = '0;
    for (int i = 0; i < NM; i++) begin
      HADDR_M[i*32 +: 32]  = m_addr[i];
      HTRANS_M[i*2 +: 2]   = m_trans[i];
      HWRITE_M[i]          = m_write[i];
      HSIZE_M[i*3 +: 3]    = m_size[i];
      HWDATA_M[i*DW +: DW] = m_wdata[i];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;

  // Reference state: who owns the data phase, and who was granted last.
  int s_dval, s_down, s_last, s_gnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  function automatic bit wants(input int i);
    return m_trans[i][1];
  endfunction

  // Who should hold the address phase this cycle.
  function automatic int ref_gnt();
    if (s_dval != 0 && m_trans[s_down] == 2'b11) return s_down;
`ifdef AHB_MUX_RR_EN
    for (int off = 1; off <= NM; off++)
      if (wants((s_last + off) % NM)) return (s_last + off) % NM;
`else
    for (int i = 0; i < NM; i++)
      if (wants(i)) return i;
`endif
    return s_last;
  endfunction

  task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [2:0] sz);
    m_trans[i] = tr;
    m_addr[i]  = a;
    m_write[i] = wr;
    m_size[i]  = sz;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NM; i++) set_m(i, 2'b00, 32'h0, 1'b0, 3'd0);
  endtask

  // Compare every output against the reference at the falling edge.
  task automatic observe(input string lbl);
    logic [NM-1:0] rdy;
    logic [NM-1:0] rsp;
    logic [DW-1:0] wd;
    logic [1:0]    tr;
    bit            own;
    @(negedge HCLK);
    s_gnt = ref_gnt();
    for (int i = 0; i < NM; i++) begin
      own    = (s_dval != 0) && (s_down == i);
      rdy[i] = (own || s_gnt == i || !wants(i)) ? HREADY : 1'b0;
      rsp[i] = (own && !HRESET) ? HRESP : 1'b0;
    end
    tr = (!HRESET && wants(s_gnt)) ? m_trans[s_gnt] : 2'b00;
    wd = (s_dval != 0) ? m_wdata[s_down] : '0;
    chk("haddr",    64'(HADDR),    64'(m_addr[s_gnt]));
    chk("hwrite",   64'(HWRITE),   64'(m_write[s_gnt]));
    chk("hsize",    64'(HSIZE),    64'(m_size[s_gnt]));
    chk("htrans",   64'(HTRANS),   64'(tr));
    chk("hwdata",   64'(HWDATA),   64'(wd));
    chk("hready_m", 64'(HREADY_M), 64'(rdy));
    chk("hresp_m",  64'(HRESP_M),  64'(rsp));
    chk("hrdata_m", 64'(HRDATA_M), 64'(HRDATA));
    $display("%s cyc %0d gnt %0d haddr %h htrans %0d hready_m %b hresp_m %b",
             lbl, cyc_no, s_gnt, HADDR, HTRANS, HREADY_M, HRESP_M);
  endtask

  // Advance the reference across the rising edge, then return just after it.
  task automatic commit();
    @(posedge HCLK);
    if (HRESET) begin
      s_dval = 0; s_down = 0; s_last = NM - 1;
    end else if (HREADY) begin
      s_dval = wants(s_gnt) ? 1 : 0;
      s_down = s_gnt;
      if (wants(s_gnt)) s_last = s_gnt;
    end
    cyc_no++;
    #1;
  endtask

  task automatic step(input string lbl);
    observe(lbl);
    commit();
  endtask

  task automatic reset_pulse();
    HRESET = 1'b1;
    step("reset");
    HRESET = 1'b0;
  endtask

  int ord[4];

  initial begin
    HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    for (int i = 0; i < NM; i++) begin
      set_m(i, 2'b10, 32'h100 * (i + 1), 1'b0, 3'd2);
      m_wdata[i] = 64'h1111_0000 + 64'(i);
    end
    repeat (2) @(posedge HCLK);
    #1;
    s_dval = 0; s_down = 0; s_last = NM - 1;

    // Reset forces the slave request idle even with all masters requesting.
    observe("rst");
    chk("rst_htrans", 64'(HTRANS), 64'd0);
    chk("rst_hresp",  64'(HRESP_M), 64'd0);
    commit();
    HRESET = 1'b0;

    // Single master, zero wait states.
    idle_all();
    set_m(1, 2'b10, 32'h2000_0010, 1'b0, 3'd2);
    observe("single");
    chk("single_haddr", 64'(HADDR), 64'h2000_0010);
    chk("single_rdy1",  64'(HREADY_M[1]), 64'd1);
    commit();
    idle_all();
    HRDATA = 64'hCAFE_0000_1234_5678;
    observe("single_data");
    chk("single_rdata", 64'(HRDATA_M), 64'hCAFE_0000_1234_5678);
    commit();

    // Contention: all three masters NONSEQ every cycle from reset.
    reset_pulse();
`ifdef AHB_MUX_RR_EN
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 0;
`else
    ord[0] = 0; ord[1] = 0; ord[2] = 0; ord[3] = 0;
`endif
    for (int i = 0; i < NM; i++) set_m(i, 2'b10, 32'h100 * (i + 1), 1'b0, 3'd2);
    for (int k = 0; k < 4; k++) begin
      observe("contend");
      chk("contend_haddr", 64'(HADDR), 64'(32'h100 * (ord[k] + 1)));
      if (k == 0) chk("contend_rdy", 64'(HREADY_M), 64'b001);
      commit();
    end

    // Burst lock: M2 INCR4, M0 joins from beat 2.
    reset_pulse();
    idle_all();
    for (int k = 0; k < 4; k++) begin
      set_m(2, (k == 0) ? 2'b10 : 2'b11, 32'h3000 + 32'(8 * k), 1'b0, 3'd3);
      if (k >= 1) set_m(0, 2'b10, 32'h0400, 1'b1, 3'd2);
      observe("burst");
      chk("burst_haddr", 64'(HADDR), 64'(32'h3000 + 32'(8 * k)));
      commit();
    end
    set_m(2, 2'b00, 32'h0, 1'b0, 3'd0);
    observe("burst_after");
    chk("burst_m0", 64'(HADDR), 64'h0400);
    commit();

    // Wait states on a write data phase.
    reset_pulse();
    idle_all();
    set_m(0, 2'b10, 32'h4000, 1'b1, 3'd2);
    m_wdata[0] = 64'hDEAD_BEEF;
    step("wr_addr");
    idle_all();
    HREADY = 1'b0;
    for (int k = 0; k < 2; k++) begin
      observe("wr_wait");
      chk("wait_hwdata", 64'(HWDATA), 64'hDEAD_BEEF);
      chk("wait_rdy0",   64'(HREADY_M[0]), 64'd0);
      commit();
    end
    HREADY = 1'b1;
    step("wr_done");

    // Error response on M1's data phase.
    set_m(1, 2'b10, 32'h5000, 1'b0, 3'd2);
    step("err_addr");
    idle_all();
    HREADY = 1'b0; HRESP = 1'b1;
    for (int k = 0; k < 2; k++) begin
      observe("err");
      chk("err_hresp", 64'(HRESP_M), 64'b010);
      commit();
    end
    HREADY = 1'b1;
    step("err_last");
    HRESP = 1'b0;

    // Reset in the middle of an M1 burst.
    m_wdata[1] = 64'h0BAD_F00D;
    set_m(1, 2'b10, 32'h6000, 1'b1, 3'd2);
    step("mid_nseq");
    set_m(1, 2'b11, 32'h6004, 1'b1, 3'd2);
    step("mid_seq");
    set_m(1, 2'b11, 32'h6008, 1'b1, 3'd2);
    HRESET = 1'b1;
    observe("mid_rst");
    chk("mid_htrans", 64'(HTRANS), 64'd0);
    commit();
    HRESET = 1'b0;
    idle_all();
    observe("mid_after");
    chk("mid_htrans_after", 64'(HTRANS), 64'd0);
    chk("mid_hwdata_after", 64'(HWDATA), 64'd0);
    commit();

    // Random traffic against the reference.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NM; i++) begin
        set_m(i, 2'($urandom_range(0, 3)), $urandom, 1'($urandom), 3'($urandom_range(0, 3)));
        m_wdata[i] = {$urandom, $urandom};
      end
      HREADY = ($urandom % 4) != 0;
      HRESP  = !HREADY && (($urandom % 2) != 0);
      HRESET = ($urandom % 50) == 0;
      HRDATA = {$urandom, $urandom};
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
